// File: rtl/muldiv_if.sv
// Handshake and operand bus between the EX stage and the M-extension sequencer.
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            flush;
    logic            stall;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    // EX stage side: issues the operation and consumes the result.
    modport master (
        output start, funct3, rs1_data, rs2_data, flush,
        input  stall, busy, done, result
    );

    // Sequencer side.
    modport slave (
        input  start, funct3, rs1_data, rs2_data, flush,
        output stall, busy, done, result
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with sign handling done on magnitudes around the core loop.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);
    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0] cnt;
    logic [2:0]       op;
    logic             res_neg;
    logic [XLEN-1:0]  opnd;
    logic [XLEN-1:0]  acc_hi;
    logic [XLEN-1:0]  acc_lo;
    logic [XLEN-1:0]  result_q;

    logic             stall_c;
    logic             done_c;

    // Magnitude of a value that is only treated as signed when 'take' is set.
    function automatic logic [XLEN-1:0] abs_val(input logic signed [XLEN-1:0] v,
                                                 input logic take);
        if (take && v[XLEN-1]) return -v;
        return v;
    endfunction

    // Conditional two's-complement negation, word and double-word widths.
    function automatic logic [XLEN-1:0] neg_word(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_wide(input logic [2*XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    logic signed [XLEN-1:0] rs1_s, rs2_s;
    logic [2:0]             f3;
    logic                   a_signed, b_signed, a_neg, b_neg, res_neg_in;
    logic [XLEN-1:0]        a_mag, b_mag;
    logic                   div_zero, div_ovf, special, accept;
    logic [XLEN-1:0]        special_val;

    assign f3    = bus.funct3;
    assign rs1_s = bus.rs1_data;
    assign rs2_s = bus.rs2_data;

    // MULH, DIV, REM treat both operands as signed; MULHSU only rs1.
    assign a_signed = (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b100) || (f3 == 3'b110);
    assign b_signed = (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b110);
    assign a_neg    = a_signed && rs1_s[XLEN-1];
    assign b_neg    = b_signed && rs2_s[XLEN-1];
    assign a_mag    = abs_val(rs1_s, a_signed);
    assign b_mag    = abs_val(rs2_s, b_signed);

    // Remainder follows the dividend; quotient and products follow the sign XOR.
    assign res_neg_in = (f3[2] && f3[1]) ? a_neg : (a_neg ^ b_neg);

    assign div_zero = f3[2] && (bus.rs2_data == '0);
    assign div_ovf  = ((f3 == 3'b100) || (f3 == 3'b110)) &&
                      (bus.rs1_data == MIN_NEG) && (bus.rs2_data == '1);
    assign special  = div_zero || div_ovf;
    assign special_val = div_zero ? (f3[1] ? bus.rs1_data : '1)
                                  : (f3[1] ? '0 : MIN_NEG);

    assign accept = (state == IDLE) && bus.start && !bus.flush;

    logic [XLEN:0]   mul_sum, div_shift, div_diff;
    logic [XLEN-1:0] mul_hi_n, mul_lo_n, div_hi_n, div_lo_n;

    // Single iteration of the multiply and divide loops from the current accumulator.
    always_comb begin
        mul_sum = {1'b0, acc_hi} + {1'b0, opnd};
        if (acc_lo[0]) {mul_hi_n, mul_lo_n} = {mul_sum, acc_lo[XLEN-1:1]};
        else           {mul_hi_n, mul_lo_n} = {1'b0, acc_hi, acc_lo[XLEN-1:1]};

        div_shift = {acc_hi, acc_lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd};
        if (!div_diff[XLEN]) begin
            div_hi_n = div_diff[XLEN-1:0];
            div_lo_n = {acc_lo[XLEN-2:0], 1'b1};
        end else begin
            div_hi_n = div_shift[XLEN-1:0];
            div_lo_n = {acc_lo[XLEN-2:0], 1'b0};
        end
    end

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   final_val;

    // Sign-correct and pick the architectural result for the latched operation.
    always_comb begin
        prod = neg_wide({acc_hi, acc_lo}, res_neg);
        case (op)
            3'b000:                 final_val = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_val = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_val = neg_word(acc_lo, res_neg);
            default:                final_val = neg_word(acc_hi, res_neg);
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state and handshake outputs; flush aborts any operation in flight.
    always_comb begin
        state_next = state;
        stall_c    = 1'b0;
        done_c     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    stall_c    = 1'b1;
                    state_next = special ? DONE : CALC;
                end
            end
            CALC: begin
                stall_c = 1'b1;
                if (bus.flush)                          state_next = IDLE;
                else if (cnt == CNT_W'(XLEN - 1))       state_next = FINAL;
            end
            FINAL: begin
                stall_c    = 1'b1;
                state_next = bus.flush ? IDLE : DONE;
            end
            DONE: begin
                done_c     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand latch on acceptance, then one loop iteration per CALC cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            op      <= f3;
            res_neg <= res_neg_in;
            cnt     <= '0;
            acc_hi  <= '0;
            if (f3[2]) begin
                acc_lo <= a_mag;
                opnd   <= b_mag;
            end else begin
                acc_lo <= b_mag;
                opnd   <= a_mag;
            end
        end else if (state == CALC) begin
            cnt <= cnt + CNT_W'(1);
            if (op[2]) {acc_hi, acc_lo} <= {div_hi_n, div_lo_n};
            else       {acc_hi, acc_lo} <= {mul_hi_n, mul_lo_n};
        end
    end

    // Result register: loaded by special cases or a completed FINAL, held otherwise.
    always_ff @(posedge clk) begin
        if (rst)                                 result_q <= '0;
        else if (accept && special)              result_q <= special_val;
        else if (state == FINAL && !bus.flush)   result_q <= final_val;
    end

    assign bus.stall  = stall_c;
    assign bus.done   = done_c;
    assign bus.busy   = (state != IDLE);
    assign bus.result = result_q;
endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative multiply/divide sequencer for the RV32M extension in the EX stage of the 5-stage pipeline. It sits beside the main ALU, which is driven by `alu_control`. It accepts one M-type operation from EX, runs a shift-add multiply or a restoring divide over XLEN cycles, and holds the pipeline with `stall` until the result is ready. EX selects `result` in place of the ALU output during the `done` cycle.

## Interface
- `XLEN`, 32, operand/result width; iteration count.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  EX holds a valid M-type instruction (opcode 0110011, funct7 0000001).
- `funct3`  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1_data`  in  XLEN  operand A (multiplicand/dividend).
- `rs2_data`  in  XLEN  operand B (multiplier/divisor).
- `flush`  in  1  EX instruction squashed (branch/trap); abort.
- `stall`  out  1  freeze IF/ID/EX; combinational.
- `busy`  out  1  state != IDLE.
- `done`  out  1  one-cycle pulse; `result` valid this cycle.
- `result`  out  XLEN  registered result.

## Operation
- States are IDLE, CALC, FINAL, DONE.
- **IDLE, `start`=1, `flush`=0:**
  - Latch funct3, operand magnitudes, sign flags, and the result sign.
  - Signed ops (MULH/DIV/REM: both operands; MULHSU: rs1 only) take the absolute value.
  - Special case, divisor zero: next state DONE. DIV/DIVU result = all ones; REM/REMU result = rs1_data.
  - Special case, DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF: next state DONE. DIV result = 0x80000000; REM result = 0.
  - Otherwise: next state CALC, iteration counter = 0.
- **CALC:**
  - One iteration per cycle.
  - Multiply: 2·XLEN accumulator. Add the multiplicand if the current multiplier bit is 1, then shift.
  - Divide: shift the remainder left, bring in the next dividend bit, and subtract the divisor when non-negative. Quotient bit = 1 on subtract.
  - Counter is $\lceil\log_2(\text{XLEN})\rceil+1$ bits. Go to FINAL when the counter reaches XLEN-1.
- **FINAL:**
  - Apply two's-complement sign correction.
  - Select the low half (MUL), high half (MULH*), quotient (DIV*), or remainder (REM*).
  - Register into `result`. Go to DONE.
- **DONE:** `done`=1, `stall`=0. Go to IDLE unconditionally. `start` is ignored in DONE; the EX instruction is still the completing one.
- Sign rules:
  - Quotient is negative when operand signs differ.
  - Remainder takes the dividend's sign.
  - MULH/MULHSU product is negative per the XOR of the effective signs.
- `result` holds its value until the next FINAL or special-case load. `flush` and `rst` never alter `result` except that reset clears it to 0.

## Timing
- Reset values: state IDLE, `result`=0, `done`=0, `busy`=0, `stall`=0.
- `stall` = (IDLE & `start` & !`flush`) | CALC | FINAL.
- Latency is counted from cycle t, where `start` is sampled in IDLE:
  - Normal: CALC occupies t+1..t+XLEN, FINAL is t+XLEN+1, `done`=1 in t+XLEN+2.
  - Special case: `done`=1 in t+1.
- `flush` in any non-IDLE state → IDLE at the next edge. No `done`, `result` unchanged, `stall` drops the following cycle.
- `flush` with `start` in IDLE: the operation is not accepted and `stall`=0.
- `rst` has priority over `flush`/`start`. Reset mid-CALC → IDLE and `result`=0 at the next edge.
- Back-to-back ops: DONE → IDLE, and the next `start` is accepted in IDLE one cycle after DONE. There is no overlap.

## Test plan
- MUL rs1=7, rs2=0xFFFFFFFD, start at t=5 → `stall`=1 t=5..38, `done`=1 only at t=39, `result`=0xFFFFFFEB.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIVU 100/7 → 14 and REMU → 2. DIV -7/2 → 0xFFFFFFFD and REM → 0xFFFFFFFF. Each completes in XLEN+2 cycles.
- Special cases, each with `done` one cycle after start:
  - DIV 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000/-1 → 0x80000000.
  - REM 0x80000000/-1 → 0.
- `flush` asserted in CALC iteration 10 → IDLE next edge, no `done`, `result` keeps its prior value.
- `rst` mid-CALC → all outputs return to reset values.
- Back-to-back MUL then DIVU with `start` held → second op completes, `done` pulses exactly twice.
